mont_const_precompute: RTL
==========================

// Module: mont_const_precompute
// PURPOSE
//  Generates the Montgomery constants for modulus n: n0p = -n^-1 mod 2^WORD_W,
//  r = 2^N_WIDTH mod n, t = 2^(2*N_WIDTH) mod n. Sits ahead of the modexp core;
//  one start/done handshake; results held until the next accepted start.
//  Bit-serial engines: r/t by shift-subtract, n0p in parallel by bit-serial lifting.
// PARAMETERS
//  N_WIDTH  1024  modulus width in bits; r/t width
//  WORD_W   32    Montgomery digit width; n0p width; must satisfy 1 <= WORD_W <= N_WIDTH
//  CNT_W    $clog2(2*N_WIDTH+1)  step-counter width (derived, not overridden)
// PORTS
//  clk    in   1        rising-edge clock
//  rst_n  in   1        asynchronous active-low reset
//  start  in   1        request; sampled only in IDLE
//  n      in   N_WIDTH  modulus; captured on the accepting edge
//  busy   out  1        computation in progress
//  done   out  1        one-cycle completion pulse
//  valid  out  1        n0p/r/t hold results for the last accepted n
//  err    out  1        last accepted n was rejected (ODD_CHECK only)
//  n0p    out  WORD_W   -n^-1 mod 2^WORD_W
//  r      out  N_WIDTH  2^N_WIDTH mod n
//  t      out  N_WIDTH  2^(2*N_WIDTH) mod n
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy/done/valid/err=0; n0p/r/t=0; counters=0.
//  States: IDLE -> RUN -> IDLE.
//  IDLE & start: latch n; x = (n==1) ? 0 : 1 (x is N_WIDTH+1 bits); acc = 0; m = 0;
//    cnt = 0; busy=1; valid=0; err=0; state=RUN. n0p/r/t keep previous values.
//  RUN, each edge (step k = cnt+1):
//    x2 = x<<1; x = (x2 >= n) ? x2-n : x2   (single conditional subtract; x < n always)
//    when k == N_WIDTH: r <= new x.
//    n0p engine, for k <= WORD_W, i = k-1: if acc[i]==0 then m[i]=1, acc += n[WORD_W-1:0]<<i
//      (mod 2^WORD_W); after WORD_W steps acc == all ones, n0p <= m.
//    when k == 2*N_WIDTH: t <= new x; busy=0; done=1; valid=1; state=IDLE.
//  Latency: done high in the cycle after the 2*N_WIDTH-th edge following the accepting edge.
//  done is a one-cycle pulse; deasserted on the next edge unconditionally.
//  start while busy: ignored, no queuing. start during the done cycle: accepted (state is IDLE).
//  n changes while busy: no effect (latched copy used).
//  rst_n low mid-RUN: abort, all outputs to reset values, no done pulse.
// CONFIGURATION
//  Macro MONT_PRECOMP_ODD_CHECK_EN:
//    defined: on accept, if n[0]==0 (includes n==0) skip RUN: next edge err=1, done=1,
//      valid=0, n0p/r/t=0; busy stays 0.
//    undefined: no check; err tied 0; even n runs the full computation; outputs
//      are deterministic but not meaningful; valid still asserts.
// STRUCTURE
//  Package mont_pkg: state enum (IDLE, RUN), default N_WIDTH/WORD_W, CNT_W helper function.
//  Sub-module mont_n0prime_serial: WORD_W-bit lifting engine (acc, m, bit index);
//    inputs: clk, rst_n, load, step, n0[WORD_W-1:0]; output: n0p. The top owns the
//    FSM, the step counter and the N_WIDTH+1-bit shift-subtract datapath.
// TESTING (N_WIDTH=8, WORD_W=8 unless stated)
//  n=8'hF1, start -> after 16 steps: done pulse, r=8'h0F, t=8'hE1, n0p=8'hEF, valid=1.
//  n=8'h03 -> r=8'h01, t=8'h01, n0p=8'h55; busy high for exactly 16 cycles.
//  n=8'h01 -> r=0, t=0, n0p=8'hFF (n==1 boundary).
//  start pulsed mid-RUN with a new n -> ignored; results match the first n; one done pulse only.
//  rst_n asserted at step 5 -> all outputs 0 immediately, no done; restart gives correct results.
//  ODD_CHECK_EN, n=8'h10 -> done and err on the next edge, valid=0, outputs 0;
//    N_WIDTH=1024, WORD_W=32, random odd n -> matches reference model after 2048 steps.

Source files
------------

// File: rtl/mont_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mont_pkg                                                      |
// | Brief    : Shared types and sizing helpers for the Montgomery constant   |
// |            precompute block.                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mont_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_N_WIDTH = 1024;
  localparam int DEF_WORD_W  = 32;

  // Step counter must reach 2*N_WIDTH.
  function automatic int cnt_w(input int n_width);
    return $clog2(2 * n_width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mont_n0prime_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mont_n0prime_serial                                           |
// | Brief    : Bit-serial lifting engine for n0p = -n^-1 mod 2^WORD_W.       |
// |            One bit of m is resolved per step; after WORD_W steps         |
// |            m*n0 == all ones, so m is the negated inverse.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mont_n0prime_serial
  import mont_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [WORD_W-1:0] n0,
  output logic [WORD_W-1:0] n0p
);

  localparam int IDX_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] m_q,   m_d;
  logic [WORD_W-1:0] n0p_q, n0p_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Next-state: clear on load, otherwise resolve bit idx when stepping.
  always_comb begin
    acc_d = acc_q;
    m_d   = m_q;
    n0p_d = n0p_q;
    idx_d = idx_q;
    if (load) begin
      acc_d = '0;
      m_d   = '0;
      idx_d = '0;
    end else if (step && (idx_q < IDX_W'(WORD_W))) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (idx_q == IDX_W'(i)) begin
          if (!acc_q[i]) begin
            m_d[i] = 1'b1;
            acc_d  = acc_q + (n0 << i);
          end
          if (i == WORD_W - 1) begin
            n0p_d = m_d;
          end
        end
      end
      idx_d = idx_q + 1'b1;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      n0p_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      n0p_q <= n0p_d;
      idx_q <= idx_d;
    end
  end

  assign n0p = n0p_q;

endmodule
`default_nettype wire

// File: rtl/mont_const_precompute.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mont_const_precompute                                         |
// | Brief    : Computes Montgomery constants n0p, r = 2^N mod n and          |
// |            t = 2^2N mod n with a bit-serial shift-subtract datapath.     |
// |            Optional macro MONT_PRECOMP_ODD_CHECK_EN rejects even moduli. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mont_const_precompute
  import mont_pkg::*;
#(
  parameter int N_WIDTH = DEF_N_WIDTH,
  parameter int WORD_W  = DEF_WORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic               err,
  output logic [WORD_W-1:0]  n0p,
  output logic [N_WIDTH-1:0] r,
  output logic [N_WIDTH-1:0] t
);

  localparam int CNT_W = cnt_w(N_WIDTH);
  localparam logic [CNT_W-1:0] R_STEP = CNT_W'(N_WIDTH - 1);
  localparam logic [CNT_W-1:0] T_STEP = CNT_W'(2 * N_WIDTH - 1);

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic [N_WIDTH:0]   x_q, x_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [N_WIDTH-1:0] r_q, r_d;
  logic [N_WIDTH-1:0] t_q, t_d;
  logic [WORD_W-1:0]  n0p_q, n0p_d;

  logic               eng_load;
  logic               eng_step;
  logic [WORD_W-1:0]  eng_n0p;
  logic [N_WIDTH:0]   x2;
  logic [N_WIDTH:0]   x_next;

  mont_n0prime_serial #(
    .WORD_W (WORD_W)
  ) u_n0p (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (eng_load),
    .step  (eng_step),
    .n0    (n_q[WORD_W-1:0]),
    .n0p   (eng_n0p)
  );

  // FSM next-state, doubling-mod-n datapath and result capture.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    err_d    = err_q;
    r_d      = r_q;
    t_d      = t_q;
    n0p_d    = n0p_q;
    eng_load = 1'b0;
    eng_step = 1'b0;
    // x < n holds, so x<<1 < 2n and one conditional subtract reduces it.
    x2       = x_q << 1;
    x_next   = (x2 >= {1'b0, n_q}) ? (x2 - {1'b0, n_q}) : x2;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d = n;
`ifdef MONT_PRECOMP_ODD_CHECK_EN
          if (!n[0]) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            valid_d = 1'b0;
            n0p_d   = '0;
            r_d     = '0;
            t_d     = '0;
          end else
`endif
          begin
            x_d      = (n == N_WIDTH'(1)) ? '0 : (N_WIDTH + 1)'(1);
            cnt_d    = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            eng_load = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        x_d      = x_next;
        cnt_d    = cnt_q + 1'b1;
        eng_step = 1'b1;
        if (cnt_q == R_STEP) begin
          r_d = x_next[N_WIDTH-1:0];
        end
        if (cnt_q == T_STEP) begin
          t_d     = x_next[N_WIDTH-1:0];
          n0p_d   = eng_n0p;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      t_q     <= '0;
      n0p_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      r_q     <= r_d;
      t_q     <= t_d;
      n0p_q   <= n0p_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign n0p   = n0p_q;
  assign r     = r_q;
  assign t     = t_q;

endmodule
`default_nettype wire
